// File: rtl/byte_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : byte_serial_add_seq
// Description : Multi-byte add/subtract sequencer wrapped around an external
//               8-bit combinational adder. It accepts wide operands over a
//               valid/ready handshake and feeds them to the adder one byte
//               per cycle, least-significant byte first. The adder carry is
//               chained between bytes. The assembled result is returned over
//               a second valid/ready handshake.
//
// Parameters  : NUM_BYTES  operand width in bytes (>= 2); W = 8*NUM_BYTES
//
// Ports       : clk, rst_n            clock (rising edge), async active-low reset
//               in_valid / in_ready   operand handshake
//               op_a, op_b [W]        operands
//               sub                   0 = A+B, 1 = A-B
//               out_valid / out_ready result handshake
//               result [W]            sum / difference (mod 2^W)
//               carry_out             final carry (sub: 1 = no borrow)
//               overflow              signed overflow (0 unless BYTE_SEQ_OVF_EN)
//               add_x, add_y [8]      byte operands to the adder
//               add_cin               carry into the adder
//               add_sum [8], add_cout adder outputs (combinational)
//
// Options     : define BYTE_SEQ_OVF_EN to enable signed-overflow detection.
//
// Revision    : 1.0  initial release
// ============================================================================

module byte_serial_add_seq #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] op_a,
    input  logic [8*NUM_BYTES-1:0] op_b,
    input  logic                   sub,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] result,
    output logic                   carry_out,
    output logic                   overflow,

    output logic [7:0]             add_x,
    output logic [7:0]             add_y,
    output logic                   add_cin,
    input  logic [7:0]             add_sum,
    input  logic                   add_cout
);

    localparam int c_W     = 8 * NUM_BYTES;
    localparam int c_IDX_W = $clog2(NUM_BYTES);
    localparam int c_OFS_W = c_IDX_W + 3;

    localparam logic [c_IDX_W-1:0] c_IDX_ZERO = '0;
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [c_W-1:0]       r_a;        // captured operand A
    logic [c_W-1:0]       r_b;        // captured operand B, pre-inverted for subtract
    logic [c_IDX_W-1:0]   r_idx;      // byte currently presented to the adder
    logic                 r_carry;    // carry chained between byte slices
    logic [c_W-1:0]       r_result;   // result assembled byte by byte

    logic [c_OFS_W-1:0]   w_byte_ofs; // bit offset of the current byte
    logic                 w_accept;
    logic                 w_last;

    assign w_byte_ofs = {r_idx, 3'b000};
    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_last     = (r_idx == c_IDX_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and handshake / adder-drive outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        add_x        = 8'h00;
        add_y        = 8'h00;
        add_cin      = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                add_x   = r_a[w_byte_ofs +: 8];
                add_y   = r_b[w_byte_ofs +: 8];
                add_cin = r_carry;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand capture and byte-serial result assembly.
    // Subtraction is done as A + ~B + 1: B is inverted at capture and the
    // initial carry is seeded with sub, so the RUN loop is identical for both.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= c_IDX_ZERO;
            r_carry  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= op_a;
                r_b     <= op_b ^ {c_W{sub}};
                r_idx   <= c_IDX_ZERO;
                r_carry <= sub;
            end else if (r_state == S_RUN) begin
                r_result[w_byte_ofs +: 8] <= add_sum;
                r_carry                   <= add_cout;
                // After the last byte idx is don't-care until the next accept
                // reloads it, so it is allowed to step past NUM_BYTES-1.
                r_idx                     <= r_idx + c_IDX_ONE;
            end
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry;

`ifdef BYTE_SEQ_OVF_EN
    // ------------------------------------------------------------------------
    // Signed overflow: operands of equal sign (after the subtract inversion)
    // producing a top byte whose sign differs from them. Evaluated while the
    // most significant byte is in the adder.
    // ------------------------------------------------------------------------
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ovf <= 1'b0;
            end else if ((r_state == S_RUN) && w_last) begin
                r_ovf <= (r_a[c_W-1] == r_b[c_W-1]) && (add_sum[7] != r_a[c_W-1]);
            end
        end
    end

    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_byte_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_serial_add_seq
// Description : Self-checking bench for byte_serial_add_seq (NUM_BYTES = 4).
//               Models the external 8-bit adder combinationally, drives a
//               table of operand vectors through the sequencer, and checks
//               results from a scoreboard queue. Hand-written sequences cover
//               result backpressure and reset during an operation.
// Revision    : 1.0  initial release
// ============================================================================

module tb_byte_serial_add_seq;

    localparam int NUM_BYTES = 4;
    localparam int W         = 8 * NUM_BYTES;
    localparam int TIMEOUT   = 20;

`ifdef BYTE_SEQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           sub;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic           carry_out;
    logic           overflow;
    logic [7:0]     add_x;
    logic [7:0]     add_y;
    logic           add_cin;
    logic [7:0]     add_sum;
    logic           add_cout;

    // Behavioural model of the external 8-bit adder
    assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {8'h00, add_cin};

    byte_serial_add_seq #(.NUM_BYTES(NUM_BYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;   // signed overflow of the operation itself
    } vec_t;

    vec_t tbl [8];
    vec_t sb_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a DUT signal condition; returns cycles waited.
    task automatic wait_out_valid(output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            step();
            lat++;
        end
        ok = out_valid;
        chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < TIMEOUT) begin
            step();
            n++;
        end
        chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    // Compare DONE outputs with the scoreboard head, then complete the
    // result handshake and check the return to IDLE.
    task automatic pop_check(input string tag);
        vec_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_carry"},  {31'b0, carry_out}, {31'b0, e.cout});
        chk({tag, "_ovf"},    {31'b0, overflow},  {31'b0, e.ovf & OVF_EN});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle_outv"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_idle_rdy"},  {31'b0, in_ready},  32'd1);
    endtask

    // Full operation: accept, first-byte adder drive, latency, result.
    task automatic do_op(input vec_t v, input string tag);
        int lat;
        bit ok;
        wait_in_ready();
        chk({tag, "_idle_addx"}, {24'b0, add_x}, 32'd0);
        in_valid = 1'b1;
        op_a     = v.a;
        op_b     = v.b;
        sub      = v.sub;
        step();                       // accept edge
        sb_q.push_back(v);
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        sub      = 1'($urandom);
        chk({tag, "_b0_x"},   {24'b0, add_x}, {24'b0, v.a[7:0]});
        chk({tag, "_b0_y"},   {24'b0, add_y}, {24'b0, v.b[7:0] ^ {8{v.sub}}});
        chk({tag, "_b0_cin"}, {31'b0, add_cin}, {31'b0, v.sub});
        chk({tag, "_busy"},   {31'b0, in_ready}, 32'd0);
        wait_out_valid(lat, ok);
        if (ok) begin
            chk({tag, "_latency"}, lat, NUM_BYTES);
            pop_check(tag);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t v;
        int lat;
        bit ok;

        //            a             b             sub   res           cout  ovf
        tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[5] = '{32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0, 1'b0};
        tbl[6] = '{32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;

        // Reset state
        #3;
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result",    result,             32'd0);
        chk("rst_carry",     {31'b0, carry_out}, 32'd0);
        chk("rst_ovf",       {31'b0, overflow},  32'd0);
        chk("rst_add",       {15'b0, add_x, add_y, add_cin}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: DONE held for 3 cycles while new operands are offered
        v = tbl[5];
        wait_in_ready();
        in_valid = 1'b1; op_a = v.a; op_b = v.b; sub = v.sub;
        step();
        sb_q.push_back(v);
        in_valid = 1'b0;
        wait_out_valid(lat, ok);
        if (ok) begin
            in_valid = 1'b1;
            op_a = 32'hAAAAAAAA; op_b = 32'h55555555; sub = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
                chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
                chk("bp_result",    result, v.res);
                chk("bp_add_x",     {24'b0, add_x}, 32'd0);
            end
            v = sb_q.pop_front();
            out_ready = 1'b1;
            step();                   // DONE -> IDLE
            out_ready = 1'b0;
            chk("bp_idle_rdy",  {31'b0, in_ready},  32'd1);
            chk("bp_idle_outv", {31'b0, out_valid}, 32'd0);
            step();                   // accept of the waiting operands
            sb_q.push_back('{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0});
            in_valid = 1'b0;
            chk("bp_accepted", {31'b0, in_ready}, 32'd0);
            wait_out_valid(lat, ok);
            if (ok) begin
                chk("bp2_latency", lat, NUM_BYTES);
                pop_check("bp2");
            end
        end

        // Reset during RUN with idx = 2
        v = tbl[3];
        wait_in_ready();
        in_valid = 1'b1; op_a = v.a; op_b = v.b; sub = v.sub;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_byte2_x", {24'b0, add_x}, {24'b0, v.a[23:16]});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outv",   {31'b0, out_valid}, 32'd0);
        chk("mid_rst_result", result,             32'd0);
        chk("mid_rst_rdy",    {31'b0, in_ready},  32'd1);
        chk("mid_rst_add",    {15'b0, add_x, add_y, add_cin}, 32'd0);
        chk("mid_rst_carry",  {31'b0, carry_out}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        sb_q.delete();
        do_op(tbl[5], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
